axil_reg_bank: RTL and testbench

//  Parametrised AXI4-Lite register bank with N_SREG read-only status registers and N_CREG read/write control registers.
//  It contains its own AW/W/B and AR/R handshake state machines, with no external slave core.

---
 rtl/axil_reg_bank_if.sv | 39 +++
 rtl/axil_reg_bank.sv | 257 +++++++++++++++++++++++++
 tb/tb_axil_reg_bank.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_reg_bank_if.sv
// AXI4-Lite slave-side bus bundle for axil_reg_bank (AW/W/B write and AR/R read channels).
// The master modport is the host view; the slave modport is the register bank view.
interface axil_reg_bank_if;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport slave (
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready
   );
endinterface

// File: rtl/axil_reg_bank.sv
// AXI4-Lite register bank: N_SREG read-only status registers followed by N_CREG masked read/write control registers.
// Optional macro AXIL_STICKY_STATUS_EN latches the STICKY_MASK status bits until the read that returns them.
module axil_reg_bank #(
   parameter int                    N_SREG       = 6,
   parameter int                    N_CREG       = 9,
   parameter int                    ADDR_BITS    = 7,
   parameter logic [N_CREG*32-1:0]  CREG_DEFAULT = {N_CREG{32'h0}},
   parameter logic [N_CREG*32-1:0]  CREG_WMASK   = {N_CREG{32'hFFFF_FFFF}},
   parameter logic [N_SREG*32-1:0]  STICKY_MASK  = {N_SREG{32'h0}}
) (
   input  logic                 clk,
   input  logic                 resetn,
   axil_reg_bank_if.slave       s_axi,
   input  logic [N_SREG*32-1:0] i_sreg,
   output logic [N_CREG*32-1:0] o_creg,
   output logic [N_CREG-1:0]    o_creg_wstrobe,
   output logic [N_SREG-1:0]    o_sreg_rstrobe
);

   localparam int IDX_W = ADDR_BITS - 2;
   localparam int N_REG = N_SREG + N_CREG;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;

   typedef enum logic {W_ADDR_DATA, W_RESP} w_state_e;
   typedef enum logic {R_ADDR, R_DATA} r_state_e;

   w_state_e           w_state_q, w_state_d;
   logic               aw_held_q, aw_held_d;
   logic               w_held_q, w_held_d;
   logic [IDX_W-1:0]   aw_idx_q, aw_idx_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [3:0]         wstrb_q, wstrb_d;
   logic               awready_q, awready_d;
   logic               wready_q, wready_d;
   logic               bvalid_q, bvalid_d;
   logic [1:0]         bresp_q, bresp_d;
   logic [31:0]        creg_q [N_CREG];
   logic [31:0]        creg_d [N_CREG];
   logic [N_CREG-1:0]  wstrobe_q, wstrobe_d;

   r_state_e           r_state_q, r_state_d;
   logic               arready_q, arready_d;
   logic               rvalid_q, rvalid_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [1:0]         rresp_q, rresp_d;
   logic [N_SREG-1:0]  rstrobe_q, rstrobe_d;

   logic [31:0]        sreg_val [N_SREG];
   logic [31:0]        byte_en;
   logic [IDX_W-1:0]   ar_idx;
   logic               ar_fire;
   logic               r_fire;

   assign byte_en = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
   assign ar_idx  = s_axi.araddr[ADDR_BITS-1:2];
   assign ar_fire = arready_q && s_axi.arvalid;
   assign r_fire  = rvalid_q && s_axi.rready;

   // AW and W are captured independently; the write commits one cycle after both are held.
   always_comb begin
      w_state_d = w_state_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      aw_idx_d  = aw_idx_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      creg_d    = creg_q;
      wstrobe_d = '0;
      case (w_state_q)
         W_ADDR_DATA: begin
            if (awready_q && s_axi.awvalid) begin
               aw_held_d = 1'b1;
               aw_idx_d  = s_axi.awaddr[ADDR_BITS-1:2];
            end
            if (wready_q && s_axi.wvalid) begin
               w_held_d = 1'b1;
               wdata_d  = s_axi.wdata;
               wstrb_d  = s_axi.wstrb;
            end
            if (aw_held_q && w_held_q) begin
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               w_state_d = W_RESP;
               bvalid_d  = 1'b1;
               if (int'(aw_idx_q) < N_SREG) begin
                  bresp_d = RESP_SLVERR;
               end else if (int'(aw_idx_q) < N_REG) begin
                  bresp_d = RESP_OKAY;
                  for (int k = 0; k < N_CREG; k++) begin
                     if (int'(aw_idx_q) == N_SREG + k) begin
                        creg_d[k] = (creg_q[k] & ~(byte_en & CREG_WMASK[32*k +: 32]))
                                  | (wdata_q & byte_en & CREG_WMASK[32*k +: 32]);
                        wstrobe_d[k] = 1'b1;
                     end
                  end
               end else begin
                  bresp_d = RESP_DECERR;
               end
            end
         end
         W_RESP: begin
            if (bvalid_q && s_axi.bready) begin
               w_state_d = W_ADDR_DATA;
               bvalid_d  = 1'b0;
            end
         end
         default: w_state_d = W_ADDR_DATA;
      endcase
      awready_d = (w_state_d == W_ADDR_DATA) && !aw_held_d;
      wready_d  = (w_state_d == W_ADDR_DATA) && !w_held_d;
   end

   // Reads sample creg_q directly, so a read on a commit edge returns the pre-write value.
   always_comb begin
      r_state_d = r_state_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rstrobe_d = '0;
      case (r_state_q)
         R_ADDR: begin
            if (ar_fire) begin
               r_state_d = R_DATA;
               rvalid_d  = 1'b1;
               rdata_d   = 32'h0;
               rresp_d   = RESP_DECERR;
               for (int k = 0; k < N_SREG; k++) begin
                  if (int'(ar_idx) == k) begin
                     rdata_d      = sreg_val[k];
                     rresp_d      = RESP_OKAY;
                     rstrobe_d[k] = 1'b1;
                  end
               end
               for (int k = 0; k < N_CREG; k++) begin
                  if (int'(ar_idx) == N_SREG + k) begin
                     rdata_d = creg_q[k];
                     rresp_d = RESP_OKAY;
                  end
               end
            end
         end
         R_DATA: begin
            if (r_fire) begin
               r_state_d = R_ADDR;
               rvalid_d  = 1'b0;
            end
         end
         default: r_state_d = R_ADDR;
      endcase
      arready_d = (r_state_d == R_ADDR);
   end

`ifdef AXIL_STICKY_STATUS_EN
   logic [31:0]       sticky_q [N_SREG];
   logic [31:0]       sticky_d [N_SREG];
   logic [N_SREG-1:0] rd_sel_q, rd_sel_d;

   // Only bits actually returned are cleared, and a same-cycle set is OR-ed in after the clear.
   always_comb begin
      rd_sel_d = ar_fire ? rstrobe_d : rd_sel_q;
      for (int k = 0; k < N_SREG; k++) begin
         sticky_d[k] = (sticky_q[k]
                       & ~((r_fire && rd_sel_q[k]) ? (rdata_q & STICKY_MASK[32*k +: 32]) : 32'h0))
                     | (i_sreg[32*k +: 32] & STICKY_MASK[32*k +: 32]);
         sreg_val[k] = (i_sreg[32*k +: 32] & ~STICKY_MASK[32*k +: 32]) | sticky_q[k];
      end
   end
`else
   logic unused_sticky;
   assign unused_sticky = ^STICKY_MASK;

   always_comb begin
      for (int k = 0; k < N_SREG; k++) begin
         sreg_val[k] = i_sreg[32*k +: 32];
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         w_state_q <= W_ADDR_DATA;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         aw_idx_q  <= '0;
         wdata_q   <= 32'h0;
         wstrb_q   <= 4'h0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'd0;
         wstrobe_q <= '0;
         for (int k = 0; k < N_CREG; k++) begin
            creg_q[k] <= CREG_DEFAULT[32*k +: 32];
         end
         r_state_q <= R_ADDR;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= 32'h0;
         rresp_q   <= 2'd0;
         rstrobe_q <= '0;
`ifdef AXIL_STICKY_STATUS_EN
         rd_sel_q  <= '0;
         for (int k = 0; k < N_SREG; k++) begin
            sticky_q[k] <= 32'h0;
         end
`endif
      end else begin
         w_state_q <= w_state_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         aw_idx_q  <= aw_idx_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         wstrobe_q <= wstrobe_d;
         creg_q    <= creg_d;
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rstrobe_q <= rstrobe_d;
`ifdef AXIL_STICKY_STATUS_EN
         rd_sel_q  <= rd_sel_d;
         sticky_q  <= sticky_d;
`endif
      end
   end

   assign s_axi.awready  = awready_q;
   assign s_axi.wready   = wready_q;
   assign s_axi.bvalid   = bvalid_q;
   assign s_axi.bresp    = bresp_q;
   assign s_axi.arready  = arready_q;
   assign s_axi.rvalid   = rvalid_q;
   assign s_axi.rdata    = rdata_q;
   assign s_axi.rresp    = rresp_q;
   assign o_creg_wstrobe = wstrobe_q;
   assign o_sreg_rstrobe = rstrobe_q;

   for (genvar g = 0; g < N_CREG; g++) begin : g_creg_out
      assign o_creg[32*g +: 32] = creg_q[g];
   end

   logic unused_bits;
   assign unused_bits = ^{s_axi.awaddr[31:ADDR_BITS], s_axi.awaddr[1:0], s_axi.awprot,
                          s_axi.araddr[31:ADDR_BITS], s_axi.araddr[1:0], s_axi.arprot};

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed self-checking bench for axil_reg_bank; honours AXIL_STICKY_STATUS_EN when it is defined.
module tb_axil_reg_bank;

   localparam int N_SREG = 6;
   localparam int N_CREG = 9;
   localparam logic [N_CREG*32-1:0] CDEF = {32'h0, 32'h0, 32'h0, 32'd2000, 32'h0,
                                            32'h0, 32'h0, 32'hA5A5_0000, 32'h0};
   localparam logic [N_CREG*32-1:0] CMASK = {{7{32'hFFFF_FFFF}}, 32'h0000_FFFF, 32'hFFFF_FFFF};
   localparam logic [N_SREG*32-1:0] SMASK = {{5{32'h0}}, 32'h0000_0008};

   logic                 clk;
   logic                 resetn;
   logic [N_SREG*32-1:0] i_sreg;
   logic [N_CREG*32-1:0] o_creg;
   logic [N_CREG-1:0]    o_creg_wstrobe;
   logic [N_SREG-1:0]    o_sreg_rstrobe;

   int n_checks = 0;
   int n_fail   = 0;

   logic [1:0]        resp;
   logic [N_CREG-1:0] wstb;
   logic [31:0]       rd;
   logic [N_SREG-1:0] rstb;
   logic [31:0]       exp_sticky;

   axil_reg_bank_if s_axi ();

   axil_reg_bank #(
      .N_SREG(N_SREG), .N_CREG(N_CREG), .ADDR_BITS(7),
      .CREG_DEFAULT(CDEF), .CREG_WMASK(CMASK), .STICKY_MASK(SMASK)
   ) dut (
      .clk(clk), .resetn(resetn), .s_axi(s_axi), .i_sreg(i_sreg),
      .o_creg(o_creg), .o_creg_wstrobe(o_creg_wstrobe), .o_sreg_rstrobe(o_sreg_rstrobe)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Full write with AW and W offered together; returns BRESP and the strobe seen with BVALID.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                output logic [1:0] bresp_o, output logic [N_CREG-1:0] strobe_o);
      bit aw_done = 0;
      bit w_done  = 0;
      bit aw_hs, w_hs;
      int cnt = 0;
      s_axi.awaddr  = addr;
      s_axi.wdata   = data;
      s_axi.wstrb   = strb;
      s_axi.awvalid = 1'b1;
      s_axi.wvalid  = 1'b1;
      while (!(aw_done && w_done) && cnt < 20) begin
         aw_hs = s_axi.awvalid && s_axi.awready;
         w_hs  = s_axi.wvalid && s_axi.wready;
         tick();
         if (aw_hs) begin s_axi.awvalid = 1'b0; aw_done = 1; end
         if (w_hs)  begin s_axi.wvalid  = 1'b0; w_done  = 1; end
         cnt++;
      end
      s_axi.awvalid = 1'b0;
      s_axi.wvalid  = 1'b0;
      checkOutput("aw_w_accept", 32'(aw_done && w_done), 32'd1);
      cnt = 0;
      while (!s_axi.bvalid && cnt < 20) begin
         tick();
         cnt++;
      end
      checkOutput("bvalid_seen", 32'(s_axi.bvalid), 32'd1);
      bresp_o  = s_axi.bresp;
      strobe_o = o_creg_wstrobe;
      s_axi.bready = 1'b1;
      tick();
      s_axi.bready = 1'b0;
   endtask

   task automatic applyRead(input logic [31:0] addr, output logic [31:0] data_o,
                            output logic [1:0] rresp_o, output logic [N_SREG-1:0] strobe_o);
      int cnt = 0;
      s_axi.araddr  = addr;
      s_axi.arvalid = 1'b1;
      while (!s_axi.arready && cnt < 20) begin
         tick();
         cnt++;
      end
      tick();
      s_axi.arvalid = 1'b0;
      checkOutput("r_latency", 32'(s_axi.rvalid), 32'd1);
      data_o   = s_axi.rdata;
      rresp_o  = s_axi.rresp;
      strobe_o = o_sreg_rstrobe;
      s_axi.rready = 1'b1;
      tick();
      s_axi.rready = 1'b0;
   endtask

   initial begin
      resetn        = 1'b0;
      i_sreg        = '0;
      s_axi.awaddr  = '0;
      s_axi.awprot  = '0;
      s_axi.awvalid = 1'b0;
      s_axi.wdata   = '0;
      s_axi.wstrb   = '0;
      s_axi.wvalid  = 1'b0;
      s_axi.bready  = 1'b0;
      s_axi.araddr  = '0;
      s_axi.arprot  = '0;
      s_axi.arvalid = 1'b0;
      s_axi.rready  = 1'b0;
      $display("[TB] start");

      tick();
      tick();
      checkOutput("rst_awready", 32'(s_axi.awready), 32'd0);
      checkOutput("rst_wready",  32'(s_axi.wready),  32'd0);
      checkOutput("rst_arready", 32'(s_axi.arready), 32'd0);
      checkOutput("rst_bvalid",  32'(s_axi.bvalid),  32'd0);
      checkOutput("rst_rvalid",  32'(s_axi.rvalid),  32'd0);
      resetn = 1'b1;
      tick();
      checkOutput("rel_awready", 32'(s_axi.awready), 32'd1);
      checkOutput("rel_wready",  32'(s_axi.wready),  32'd1);
      checkOutput("rel_arready", 32'(s_axi.arready), 32'd1);
      checkOutput("rel_creg5",   o_creg[32*5 +: 32], 32'd2000);
      checkOutput("rel_creg1",   o_creg[32*1 +: 32], 32'hA5A5_0000);
      checkOutput("rel_wstrobe", 32'(o_creg_wstrobe), 32'h0);

      // AW two cycles ahead of W
      s_axi.awaddr  = 32'h18;
      s_axi.awvalid = 1'b1;
      tick();
      s_axi.awvalid = 1'b0;
      checkOutput("aw_first_awready", 32'(s_axi.awready), 32'd0);
      checkOutput("aw_first_wready",  32'(s_axi.wready),  32'd1);
      tick();
      tick();
      s_axi.wdata  = 32'hDEAD_BEEF;
      s_axi.wstrb  = 4'hF;
      s_axi.wvalid = 1'b1;
      tick();
      s_axi.wvalid = 1'b0;
      checkOutput("held_bvalid", 32'(s_axi.bvalid), 32'd0);
      tick();
      checkOutput("commit_creg0",   o_creg[0 +: 32], 32'hDEAD_BEEF);
      checkOutput("commit_wstrobe", 32'(o_creg_wstrobe), 32'h001);
      checkOutput("commit_bvalid",  32'(s_axi.bvalid), 32'd1);
      checkOutput("commit_bresp",   32'(s_axi.bresp),  32'd0);
      tick();
      checkOutput("wstrobe_1cyc", 32'(o_creg_wstrobe), 32'h0);
      checkOutput("bvalid_hold",  32'(s_axi.bvalid),   32'd1);
      s_axi.bready = 1'b1;
      tick();
      s_axi.bready = 1'b0;
      checkOutput("b_done_bvalid",  32'(s_axi.bvalid),  32'd0);
      checkOutput("b_done_awready", 32'(s_axi.awready), 32'd1);
      checkOutput("b_done_wready",  32'(s_axi.wready),  32'd1);

      applyStimulus(32'h18, 32'h1122_3344, 4'b0101, resp, wstb);
      checkOutput("strb0101_creg0", o_creg[0 +: 32], 32'hDE22_BE44);
      checkOutput("strb0101_resp",  32'(resp), 32'd0);
      checkOutput("strb0101_stb",   32'(wstb), 32'h001);

      applyStimulus(32'h20, 32'hFFFF_FFFF, 4'b0000, resp, wstb);
      checkOutput("strb0_creg2", o_creg[32*2 +: 32], 32'h0);
      checkOutput("strb0_stb",   32'(wstb), 32'h004);
      checkOutput("strb0_resp",  32'(resp), 32'd0);

      applyStimulus(32'h1C, 32'hFFFF_FFFF, 4'hF, resp, wstb);
      checkOutput("wmask_creg1", o_creg[32*1 +: 32], 32'hA5A5_FFFF);
      checkOutput("wmask_stb",   32'(wstb), 32'h002);

      applyStimulus(32'h08, 32'h5555_5555, 4'hF, resp, wstb);
      checkOutput("sreg_wr_resp", 32'(resp), 32'd2);
      checkOutput("sreg_wr_stb",  32'(wstb), 32'h0);
      checkOutput("sreg_wr_creg0", o_creg[0 +: 32], 32'hDE22_BE44);

      applyStimulus(32'h50, 32'h5555_5555, 4'hF, resp, wstb);
      checkOutput("unmap_wr_resp", 32'(resp), 32'd3);
      checkOutput("unmap_wr_stb",  32'(wstb), 32'h0);

      // Upper and low address bits are ignored: 0xFFFFFFA3 decodes to index 8 (creg2)
      applyStimulus(32'hFFFF_FFA3, 32'hCAFE_F00D, 4'hF, resp, wstb);
      checkOutput("alias_creg2", o_creg[32*2 +: 32], 32'hCAFE_F00D);
      checkOutput("alias_stb",   32'(wstb), 32'h004);
      applyRead(32'h20, rd, resp, rstb);
      checkOutput("rd_creg2",      rd, 32'hCAFE_F00D);
      checkOutput("rd_creg2_rstb", 32'(rstb), 32'h0);

      applyRead(32'h7C, rd, resp, rstb);
      checkOutput("rd_unmap_data", rd, 32'h0);
      checkOutput("rd_unmap_resp", 32'(resp), 32'd3);
      checkOutput("rd_unmap_rstb", 32'(rstb), 32'h0);

      // Read status 1 with RREADY held low for five cycles
      i_sreg[32*1 +: 32] = 32'h1234_5678;
      s_axi.araddr  = 32'h04;
      s_axi.arvalid = 1'b1;
      tick();
      s_axi.arvalid = 1'b0;
      checkOutput("stall_rvalid0", 32'(s_axi.rvalid), 32'd1);
      checkOutput("stall_rdata0",  s_axi.rdata, 32'h1234_5678);
      checkOutput("stall_rresp0",  32'(s_axi.rresp), 32'd0);
      checkOutput("stall_rstb0",   32'(o_sreg_rstrobe), 32'h02);
      checkOutput("stall_arready", 32'(s_axi.arready), 32'd0);
      i_sreg[32*1 +: 32] = 32'h0BAD_0BAD;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("stall_rvalid", 32'(s_axi.rvalid), 32'd1);
         checkOutput("stall_rdata",  s_axi.rdata, 32'h1234_5678);
         checkOutput("stall_rstb",   32'(o_sreg_rstrobe), 32'h0);
      end
      s_axi.rready = 1'b1;
      tick();
      s_axi.rready = 1'b0;
      checkOutput("stall_done_rvalid",  32'(s_axi.rvalid),  32'd0);
      checkOutput("stall_done_arready", 32'(s_axi.arready), 32'd1);

      applyRead(32'h18, rd, resp, rstb);
      checkOutput("rd_creg0",      rd, 32'hDE22_BE44);
      checkOutput("rd_creg0_resp", 32'(resp), 32'd0);

      // Sticky status bit 3 of status 0
      i_sreg[0 +: 32] = 32'h0000_0008;
      tick();
      i_sreg[0 +: 32] = 32'h0;
      tick();
`ifdef AXIL_STICKY_STATUS_EN
      exp_sticky = 32'h8;
`else
      exp_sticky = 32'h0;
`endif
      applyRead(32'h00, rd, resp, rstb);
      checkOutput("sticky_rd1",      rd, exp_sticky);
      checkOutput("sticky_rd1_rstb", 32'(rstb), 32'h01);
      applyRead(32'h00, rd, resp, rstb);
      checkOutput("sticky_rd2", rd, 32'h0);
      i_sreg[0 +: 32] = 32'h0000_0055;
      applyRead(32'h00, rd, resp, rstb);
      checkOutput("live_rd", rd, 32'h0000_0055);

      // Read sampled on the commit edge of a write to the same register
      s_axi.awaddr  = 32'h24;
      s_axi.wdata   = 32'h0000_0077;
      s_axi.wstrb   = 4'hF;
      s_axi.awvalid = 1'b1;
      s_axi.wvalid  = 1'b1;
      tick();
      s_axi.awvalid = 1'b0;
      s_axi.wvalid  = 1'b0;
      s_axi.araddr  = 32'h24;
      s_axi.arvalid = 1'b1;
      tick();
      s_axi.arvalid = 1'b0;
      checkOutput("raw_rvalid", 32'(s_axi.rvalid), 32'd1);
      checkOutput("raw_rdata",  s_axi.rdata, 32'h0);
      checkOutput("raw_creg3",  o_creg[32*3 +: 32], 32'h0000_0077);
      checkOutput("raw_bvalid", 32'(s_axi.bvalid), 32'd1);
      s_axi.bready = 1'b1;
      s_axi.rready = 1'b1;
      tick();
      s_axi.bready = 1'b0;
      s_axi.rready = 1'b0;

      // Reset while BVALID and RVALID are pending
      s_axi.awaddr  = 32'h18;
      s_axi.wdata   = 32'h0000_0001;
      s_axi.awvalid = 1'b1;
      s_axi.wvalid  = 1'b1;
      s_axi.araddr  = 32'h04;
      s_axi.arvalid = 1'b1;
      tick();
      s_axi.awvalid = 1'b0;
      s_axi.wvalid  = 1'b0;
      s_axi.arvalid = 1'b0;
      tick();
      checkOutput("pre_rst_bvalid", 32'(s_axi.bvalid), 32'd1);
      checkOutput("pre_rst_rvalid", 32'(s_axi.rvalid), 32'd1);
      resetn = 1'b0;
      tick();
      checkOutput("mid_rst_bvalid",  32'(s_axi.bvalid),  32'd0);
      checkOutput("mid_rst_rvalid",  32'(s_axi.rvalid),  32'd0);
      checkOutput("mid_rst_awready", 32'(s_axi.awready), 32'd0);
      checkOutput("mid_rst_creg0",   o_creg[0 +: 32], 32'h0);
      resetn = 1'b1;
      tick();
      checkOutput("post_rst_awready", 32'(s_axi.awready), 32'd1);
      checkOutput("post_rst_bvalid",  32'(s_axi.bvalid),  32'd0);
      applyStimulus(32'h28, 32'h0BAD_F00D, 4'hF, resp, wstb);
      checkOutput("post_rst_creg4", o_creg[32*4 +: 32], 32'h0BAD_F00D);
      checkOutput("post_rst_resp",  32'(resp), 32'd0);
      checkOutput("post_rst_stb",   32'(wstb), 32'h010);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
